// File: rtl/ctr_step_monitor.sv
// rtl/ctr_step_monitor.sv - count-bus step monitor: direction, wrap, illegal-step and extended-count recovery (optional err_cnt via CTR_STEP_MONITOR_ERR_CNT_EN)
module ctr_step_monitor #(
    parameter int WIDTH  = 5,
    parameter int EXT    = 3,
    parameter int LOCK_N = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   sample_en,
    input  logic [WIDTH-1:0]       count_in,
    output logic                   dir,
    output logic                   locked,
    output logic                   wrap_pulse,
    output logic                   err_pulse,
    output logic [WIDTH+EXT-1:0]   ext_count
`ifdef CTR_STEP_MONITOR_ERR_CNT_EN
    ,
    output logic [7:0]             err_cnt
`endif
);

    localparam logic [1:0] ST_UNSYNC  = 2'd0;
    localparam logic [1:0] ST_ACQUIRE = 2'd1;
    localparam logic [1:0] ST_LOCKED  = 2'd2;

    localparam logic [3:0] LOCK_C = LOCK_N[3:0];

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [EXT-1:0]   upper_q, upper_d;
    logic [3:0]       step_q, step_d;
    logic             dir_q, dir_d;
    logic             locked_q, locked_d;
    logic             wrap_q, wrap_d;
    logic             err_q, err_d;

    logic [WIDTH-1:0] delta;
    logic [3:0]       step_inc;
    logic             is_hold, is_up, is_down, is_legal;
    logic             up_wrap, down_wrap;

`ifdef CTR_STEP_MONITOR_ERR_CNT_EN
    logic [7:0]       err_cnt_q, err_cnt_d;
`endif

    // Classify the step between the previous and the current sample
    always_comb begin
        delta     = count_in - prev_q;
        step_inc  = step_q + 4'd1;
        is_hold   = (delta == '0);
        is_up     = (delta == WIDTH'(1));
        is_down   = (delta == '1);
        is_legal  = is_hold | is_up | is_down;
        up_wrap   = is_up & (prev_q == '1);
        down_wrap = is_down & (prev_q == '0);
    end

    // Next-state logic: pulses default low, everything else holds unless a sample arrives
    always_comb begin
        state_d  = state_q;
        prev_d   = prev_q;
        upper_d  = upper_q;
        step_d   = step_q;
        dir_d    = dir_q;
        locked_d = locked_q;
        wrap_d   = 1'b0;
        err_d    = 1'b0;
        if (sample_en) begin
            prev_d = count_in;
            // The very first sample has no predecessor, so it cannot set a direction
            if (state_q != ST_UNSYNC) begin
                if (is_up) begin
                    dir_d = 1'b0;
                end else if (is_down) begin
                    dir_d = 1'b1;
                end
            end
            case (state_q)
                ST_UNSYNC: begin
                    upper_d = '0;
                    step_d  = '0;
                    state_d = ST_ACQUIRE;
                end
                ST_ACQUIRE: begin
                    if (!is_legal) begin
                        err_d  = 1'b1;
                        step_d = '0;
                    end else if (!is_hold) begin
                        step_d = step_inc;
                        if (step_inc == LOCK_C) begin
                            state_d  = ST_LOCKED;
                            locked_d = 1'b1;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (!is_legal) begin
                        err_d    = 1'b1;
                        locked_d = 1'b0;
                        step_d   = '0;
                        state_d  = ST_ACQUIRE;
                    end else if (up_wrap) begin
                        upper_d = upper_q + EXT'(1);
                        wrap_d  = 1'b1;
                    end else if (down_wrap) begin
                        upper_d = upper_q - EXT'(1);
                        wrap_d  = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_UNSYNC;
                end
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_UNSYNC;
            prev_q   <= '0;
            upper_q  <= '0;
            step_q   <= '0;
            dir_q    <= 1'b0;
            locked_q <= 1'b0;
            wrap_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            prev_q   <= prev_d;
            upper_q  <= upper_d;
            step_q   <= step_d;
            dir_q    <= dir_d;
            locked_q <= locked_d;
            wrap_q   <= wrap_d;
            err_q    <= err_d;
        end
    end

`ifdef CTR_STEP_MONITOR_ERR_CNT_EN
    // Saturating error count, cleared whenever lock is (re)gained
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (state_d == ST_LOCKED && state_q != ST_LOCKED) begin
            err_cnt_d = '0;
        end else if (err_d && err_cnt_q != 8'hFF) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    // Error counter register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`endif

    assign dir        = dir_q;
    assign locked     = locked_q;
    assign wrap_pulse = wrap_q;
    assign err_pulse  = err_q;
    assign ext_count  = {upper_q, prev_q};

endmodule

// File: tb/tb_ctr_step_monitor.sv
// tb/tb_ctr_step_monitor.sv - self-checking bench for ctr_step_monitor
module tb_ctr_step_monitor;

    localparam int WIDTH  = 5;
    localparam int EXT    = 3;
    localparam int LOCK_N = 4;
    localparam int MOD    = 1 << WIDTH;
    localparam int EMOD   = 1 << EXT;

    logic                 clk;
    logic                 rst;
    logic                 sample_en;
    logic [WIDTH-1:0]     count_in;
    logic                 dir;
    logic                 locked;
    logic                 wrap_pulse;
    logic                 err_pulse;
    logic [WIDTH+EXT-1:0] ext_count;
`ifdef CTR_STEP_MONITOR_ERR_CNT_EN
    logic [7:0]           err_cnt;
`endif

    ctr_step_monitor #(.WIDTH(WIDTH), .EXT(EXT), .LOCK_N(LOCK_N)) dut (
        .clk        (clk),
        .rst        (rst),
        .sample_en  (sample_en),
        .count_in   (count_in),
        .dir        (dir),
        .locked     (locked),
        .wrap_pulse (wrap_pulse),
        .err_pulse  (err_pulse),
        .ext_count  (ext_count)
`ifdef CTR_STEP_MONITOR_ERR_CNT_EN
        ,
        .err_cnt    (err_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: mode 0 = waiting for first sample, 1 = acquiring, 2 = locked
    int m_mode, m_prev, m_upper, m_steps, m_dir, m_locked, m_wrap, m_err, m_errcnt;

    task automatic model_reset();
        m_mode = 0; m_prev = 0; m_upper = 0; m_steps = 0;
        m_dir = 0; m_locked = 0; m_wrap = 0; m_err = 0; m_errcnt = 0;
    endtask

    task automatic model_apply(input bit en, input int c);
        int d;
        m_wrap = 0;
        m_err  = 0;
        if (!en) return;
        if (m_mode == 0) begin
            m_prev = c; m_upper = 0; m_steps = 0; m_mode = 1;
            return;
        end
        d = (c - m_prev + MOD) % MOD;
        if (d == 1) m_dir = 0;
        if (d == MOD - 1) m_dir = 1;
        if (d != 0 && d != 1 && d != MOD - 1) begin
            m_err = 1;
            m_steps = 0;
            m_locked = 0;
            m_mode = 1;
            if (m_errcnt < 255) m_errcnt++;
        end else if (m_mode == 1) begin
            if (d != 0) begin
                m_steps++;
                if (m_steps == LOCK_N) begin
                    m_mode = 2; m_locked = 1; m_errcnt = 0;
                end
            end
        end else begin
            if (d == 1 && c == 0) begin
                m_upper = (m_upper + 1) % EMOD; m_wrap = 1;
            end else if (d == MOD - 1 && c == MOD - 1) begin
                m_upper = (m_upper + EMOD - 1) % EMOD; m_wrap = 1;
            end
        end
        m_prev = c;
    endtask

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        check("dir", int'(dir), m_dir);
        check("locked", int'(locked), m_locked);
        check("wrap_pulse", int'(wrap_pulse), m_wrap);
        check("err_pulse", int'(err_pulse), m_err);
        check("ext_count", int'(ext_count), m_upper * MOD + m_prev);
`ifdef CTR_STEP_MONITOR_ERR_CNT_EN
        check("err_cnt", int'(err_cnt), m_errcnt);
`endif
    endtask

    // Apply one cycle of stimulus at a falling edge, then compare after the next rising edge
    task automatic drive(input bit en, input int c);
        sample_en = en;
        count_in  = WIDTH'(c);
        model_apply(en, c);
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    // Assert reset between clock edges and verify the outputs clear without a clock
    task automatic async_reset();
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check("rst_locked", int'(locked), 0);
        check("rst_ext", int'(ext_count), 0);
        check("rst_dir", int'(dir), 0);
        check("rst_pulses", int'(wrap_pulse) + int'(err_pulse), 0);
        @(negedge clk);
        rst = 1'b1;
        compare_all();
    endtask

    initial begin
        int v, r;
        rst = 1'b0;
        sample_en = 1'b0;
        count_in = '0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        compare_all();
        rst = 1'b1;
        @(negedge clk);
        compare_all();

        // Lock acquisition 0..4
        for (int i = 0; i <= 4; i++) drive(1'b1, i);
        check("t1_locked", int'(locked), 1);
        check("t1_ext", int'(ext_count), 4);
        check("t1_model_pin", m_upper * MOD + m_prev + m_locked * 100, 104);

        // Up to 30, 31, 0 wrap, then down-wrap to 31
        for (int i = 5; i <= 31; i++) drive(1'b1, i);
        drive(1'b1, 0);
        check("t2_wrap", int'(wrap_pulse), 1);
        check("t2_ext_up", int'(ext_count), 'h20);
        drive(1'b1, 31);
        check("t2_wrap_dn", int'(wrap_pulse), 1);
        check("t2_ext_dn", int'(ext_count), 'h1F);
        drive(1'b0, 31);
        check("t2_wrap_once", int'(wrap_pulse), 0);

        // Down to 10, then 11,11,10,9
        for (int i = 30; i >= 10; i--) drive(1'b1, i);
        drive(1'b1, 11);
        check("t3_dir_up", int'(dir), 0);
        drive(1'b1, 11);
        check("t3_dir_hold", int'(dir), 0);
        drive(1'b1, 10);
        check("t3_dir_dn", int'(dir), 1);
        drive(1'b1, 9);
        check("t3_locked", int'(locked), 1);

        // Down to 7, illegal jump to 12, relock over 13..16
        drive(1'b1, 8);
        drive(1'b1, 7);
        drive(1'b1, 12);
        check("t4_err", int'(err_pulse), 1);
        check("t4_unlock", int'(locked), 0);
        for (int i = 13; i <= 15; i++) drive(1'b1, i);
        check("t4_not_yet", int'(locked), 0);
        drive(1'b1, 16);
        check("t4_relock", int'(locked), 1);
        check("t4_ext", int'(ext_count), 16);

        // Climb to ext_count 0x45 through two up-wraps, toggle sample_en, async reset
        for (int k = 17; k <= 69; k++) drive(1'b1, k % MOD);
        check("t5_ext45", int'(ext_count), 'h45);
        for (int k = 0; k < 4; k++) drive(k[0], 5);
        async_reset();
        drive(1'b1, 20);
        check("t5_no_err", int'(err_pulse), 0);
        check("t5_ext20", int'(ext_count), 20);

`ifdef CTR_STEP_MONITOR_ERR_CNT_EN
        // Saturate the error counter, then clear it by relocking
        v = 20;
        for (int k = 0; k < 300; k++) begin
            v = (v + 16) % MOD;
            drive(1'b1, v);
        end
        check("t6_sat", int'(err_cnt), 255);
        for (int k = 1; k <= LOCK_N; k++) drive(1'b1, (v + k) % MOD);
        check("t6_clear", int'(err_cnt), 0);
`endif

        // Randomized step stream
        v = int'(count_in);
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) async_reset();
            r = $urandom_range(0, 99);
            if (r < 8) begin
                drive(1'b0, $urandom_range(0, MOD - 1));
            end else begin
                if (r < 20)      v = v;
                else if (r < 58) v = (v + 1) % MOD;
                else if (r < 92) v = (v + MOD - 1) % MOD;
                else             v = $urandom_range(0, MOD - 1);
                drive(1'b1, v);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ctr_step_monitor.md
Name: ctr_step_monitor

Overview:
- Receiving end of the 5-bit up/down counter interface: samples the counter's count bus and reconstructs what the counter did.
- Recovers count direction, detects wrap-around, flags illegal jumps, and keeps an extended count.
- Sits beside the counter in benches and in integration logic; consumes only count and a sample strobe.

Parameters:
WIDTH, 5, width of the observed count bus
EXT, 3, extra upper bits of the extended count (wrap accumulator)
LOCK_N, 4, consecutive legal steps required to declare lock (1..15)

Ports:
clk  input  1  rising-edge clock
rst  input  1  reset; asynchronous, active-low (0 = reset)
sample_en  input  1  count_in is valid this cycle
count_in  input  WIDTH  observed counter value
dir  output  1  last non-hold step direction; 1 = down, 0 = up (matches counter up_down sense)
locked  output  1  monitor is locked to a legal step stream
wrap_pulse  output  1  one-cycle pulse on a wrap while locked
err_pulse  output  1  one-cycle pulse on an illegal step
ext_count  output  WIDTH+EXT  {wrap accumulator, last sampled count}

Behaviour:
- Reset (rst=0, async): state=UNSYNC, dir=0, locked=0, wrap_pulse=0, err_pulse=0, ext_count=0, prev=0, step counter=0.
- All outputs are registered and update on the clk edge that samples sample_en=1 (1-cycle latency). With sample_en=0, only the pulses clear; everything else holds.
- Step classification: delta = (count_in - prev) mod 2^WIDTH.
  - delta==0: HOLD. Legal; dir unchanged; does not advance the lock counter.
  - delta==1: UP. Legal; dir=0.
  - delta==2^WIDTH-1: DOWN. Legal; dir=1.
  - Any other delta: ILLEGAL.
- Wrap:
  - UP with prev==2^WIDTH-1 and count_in==0 is an up-wrap.
  - DOWN with prev==0 and count_in==2^WIDTH-1 is a down-wrap.
- FSM:
  - UNSYNC: first sample loads prev and ext_count low bits; upper bits=0; go ACQUIRE with step counter=0. No pulses.
  - ACQUIRE:
    - UP/DOWN: increment step counter; on reaching LOCK_N, go LOCKED and set locked=1 in that same update.
    - ILLEGAL: err_pulse=1; step counter=0; stay in ACQUIRE.
    - Wraps here do not change the upper bits and give no wrap_pulse.
  - LOCKED:
    - Legal steps keep lock. A direction reversal is legal.
    - Up-wrap: upper bits +1 (mod 2^EXT), wrap_pulse=1.
    - Down-wrap: upper bits -1 (mod 2^EXT), wrap_pulse=1.
    - ILLEGAL: err_pulse=1; locked=0; go ACQUIRE with step counter=0; upper bits held.
- ext_count low WIDTH bits always equal the last sampled count_in (after UNSYNC).
- prev updates on every sample, including illegal samples.
- Reset asserted mid-operation returns immediately to the reset state; the first sample after release is an UNSYNC load and is never flagged illegal.

Optional Feature:
CTR_STEP_MONITOR_ERR_CNT_EN
- Defined: adds output err_cnt [7:0], an error counter.
  - Reset 0.
  - Increments on every err_pulse; saturates at 255.
  - Cleared when the FSM enters LOCKED.
- Undefined: no err_cnt port and no counter logic; all other behaviour is identical.

Test Plan:
1. Reset, then samples 0,1,2,3,4 (WIDTH=5, LOCK_N=4) -> locked=1 one cycle after the sample of 4; dir=0; ext_count=4; no err_pulse.
2. Locked, up through 30,31,0 -> wrap_pulse=1 for exactly one cycle after sample 0; ext_count=0x20. Then 31 -> down-wrap pulse; ext_count=0x1F.
3. Locked at 10; samples 11,11,10,9 -> dir=0 then 1; locked stays 1; no err_pulse; holds do not toggle dir.
4. Locked at 7; sample 12 -> err_pulse=1 and locked=0 one cycle later. Then 13,14,15,16 -> relock after the 4th legal step; upper bits unchanged.
5. Locked with ext_count=0x45 and sample_en toggling; assert rst=0 between clock edges -> all outputs 0 immediately. After release, first sample 20 -> no err_pulse; ext_count=20.
6. With CTR_STEP_MONITOR_ERR_CNT_EN: 300 illegal samples in ACQUIRE -> err_cnt=255; then LOCK_N legal steps -> err_cnt=0.
